matrix_mult_array: RTL and testbench

Parametrised N×N integer matrix-multiply engine; successor to the fixed 8×8 unsigned multiplier. It computes C = A·B, or C += A·B in accumulate mode, over DATA_W-bit signed or unsigned operands, with saturating ACC_W-bit accumulators and a sticky overflow flag. It sits behind the bus-facing peripheral wrapper, which supplies flattened operand matrices and collects the registered result.

---
 rtl/matrix_mult_pkg.sv | 25 ++
 rtl/matrix_mult_mac.sv | 70 +++++++
 rtl/matrix_mult_array.sv | 150 +++++++++++++++
 tb/tb_matrix_mult_array.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types, default sizes and helpers for the N x N matrix-multiply engine.
package matrix_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        MAC  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_N      = 8;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 16;

    // Ceiling log2, never less than 1 so a counter always has at least one bit.
    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return (w == 0) ? 1 : w;
    endfunction

endpackage

// File: rtl/matrix_mult_mac.sv
// One processing element: saturating multiply-accumulate for a single result cell.
module matrix_mult_mac
    import matrix_mult_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic              HCLK,
    input  logic              reset,
    input  logic              clear,
    input  logic              en,
    input  logic              signed_mode,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [ACC_W-1:0]  acc,
    output logic              sat
);

    localparam int PW = 2 * DATA_W;

    logic [PW-1:0]    w_a_ext;
    logic [PW-1:0]    w_b_ext;
    logic [PW-1:0]    w_prod;
    logic [ACC_W:0]   w_prod_ext;
    logic [ACC_W:0]   w_acc_ext;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W-1:0] w_next;
    logic             w_clamp;
    logic [ACC_W-1:0] r_acc;

    // Extend operands to product width; the low PW bits of the product are
    // correct for both signed and unsigned interpretation. The sum carries one
    // guard bit so overflow is visible before clamping.
    always_comb begin
        w_a_ext    = signed_mode ? {{DATA_W{a[DATA_W-1]}}, a} : {{DATA_W{1'b0}}, a};
        w_b_ext    = signed_mode ? {{DATA_W{b[DATA_W-1]}}, b} : {{DATA_W{1'b0}}, b};
        w_prod     = w_a_ext * w_b_ext;
        w_prod_ext = signed_mode ? {{(ACC_W+1-PW){w_prod[PW-1]}}, w_prod}
                                 : {{(ACC_W+1-PW){1'b0}}, w_prod};
        w_acc_ext  = signed_mode ? {r_acc[ACC_W-1], r_acc} : {1'b0, r_acc};
        w_sum      = w_acc_ext + w_prod_ext;
        w_next     = w_sum[ACC_W-1:0];
        if (signed_mode) begin
            w_clamp = (w_sum[ACC_W] != w_sum[ACC_W-1]);
            if (w_clamp) begin
                w_next = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
            end
        end else begin
            w_clamp = w_sum[ACC_W];
            if (w_clamp) begin
                w_next = {ACC_W{1'b1}};
            end
        end
    end

    // Accumulator register: cleared on reset or load-clear, updated on each MAC step.
    always_ff @(posedge HCLK) begin
        if (reset) begin
            r_acc <= '0;
        end else if (clear) begin
            r_acc <= '0;
        end else if (en) begin
            r_acc <= w_next;
        end
    end

    assign acc = r_acc;
    assign sat = en & w_clamp;

endmodule

// File: rtl/matrix_mult_array.sv
// N x N matrix-multiply engine: FSM, k counter, operand latches, row/column
// operand muxes, PE array, result register and overflow collection.
//
//  state | meaning
//  IDLE  | waiting for start; result/overflow hold last operation
//  LOAD  | optionally clear accumulators, clear overflow, k = 0
//  MAC   | every PE adds A[i][k]*B[k][j]; N cycles
//  DONE  | capture accumulators into result, pulse done
module matrix_mult_array
    import matrix_mult_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int DATA_W = DEF_DATA_W,
    parameter int ACC_W  = DEF_ACC_W
) (
    input  logic                    HCLK,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    accumulate,
    input  logic                    signed_mode,
    input  logic [N*N*DATA_W-1:0]   A_data,
    input  logic [N*N*DATA_W-1:0]   B_data,
    output logic                    busy,
    output logic                    done,
    output logic                    overflow,
    output logic [N*N*ACC_W-1:0]    result
);

    localparam int K_W = clog2(N + 1);

    state_t                  r_state;
    logic [K_W-1:0]          r_k;
    logic [N*N*DATA_W-1:0]   r_a;
    logic [N*N*DATA_W-1:0]   r_b;
    logic                    r_accumulate;
    logic                    r_signed;
    logic                    r_busy;
    logic                    r_done;
    logic                    r_overflow;
    logic [N*N*ACC_W-1:0]    r_result;

    logic [N*N*ACC_W-1:0]    w_acc;
    logic [N*N-1:0]          w_sat;
    logic                    w_clear;
    logic                    w_en;
    logic                    w_last_k;
    logic [DATA_W-1:0]       w_a_k [N];
    logic [DATA_W-1:0]       w_b_k [N];

    assign w_clear  = (r_state == LOAD) && !r_accumulate;
    assign w_en     = (r_state == MAC);
    assign w_last_k = (r_k == K_W'(N - 1));

    // Column k of A feeds every row; row k of B feeds every column.
    always_comb begin
        for (int x = 0; x < N; x++) begin
            w_a_k[x] = '0;
            w_b_k[x] = '0;
        end
        for (int kk = 0; kk < N; kk++) begin
            if (r_k == K_W'(kk)) begin
                for (int x = 0; x < N; x++) begin
                    w_a_k[x] = r_a[DATA_W*(x*N+kk) +: DATA_W];
                    w_b_k[x] = r_b[DATA_W*(kk*N+x) +: DATA_W];
                end
            end
        end
    end

    // Sequencer with registered busy/done/overflow/result.
    always_ff @(posedge HCLK) begin
        if (reset) begin
            r_state      <= IDLE;
            r_k          <= '0;
            r_a          <= '0;
            r_b          <= '0;
            r_accumulate <= 1'b0;
            r_signed     <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
            r_result     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a          <= A_data;
                        r_b          <= B_data;
                        r_accumulate <= accumulate;
                        r_signed     <= signed_mode;
                        r_busy       <= 1'b1;
                        r_state      <= LOAD;
                    end
                end
                LOAD: begin
                    r_overflow <= 1'b0;
                    r_k        <= '0;
                    r_state    <= MAC;
                end
                MAC: begin
                    if (|w_sat) begin
                        r_overflow <= 1'b1;
                    end
                    if (w_last_k) begin
                        r_k     <= '0;
                        r_state <= DONE;
                    end else begin
                        r_k <= r_k + K_W'(1);
                    end
                end
                DONE: begin
                    r_result <= w_acc;
                    r_done   <= 1'b1;
                    r_busy   <= 1'b0;
                    r_state  <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            matrix_mult_mac #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_mac (
                .HCLK        (HCLK),
                .reset       (reset),
                .clear       (w_clear),
                .en          (w_en),
                .signed_mode (r_signed),
                .a           (w_a_k[gi]),
                .b           (w_b_k[gj]),
                .acc         (w_acc[ACC_W*(gi*N+gj) +: ACC_W]),
                .sat         (w_sat[gi*N+gj])
            );
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_overflow;
    assign result   = r_result;

endmodule

// File: tb/tb_matrix_mult_array.sv
// Self-checking bench for matrix_mult_array (N=8, DATA_W=8, ACC_W=16 and 24).
module tb_matrix_mult_array;

    localparam int N   = 8;
    localparam int DW  = 8;
    localparam int AW  = 16;
    localparam int AW2 = 24;
    localparam int VW  = N * N * DW;

    logic                 HCLK = 1'b0;
    logic                 reset;
    logic                 start;
    logic                 accumulate;
    logic                 signed_mode;
    logic [VW-1:0]        A_data;
    logic [VW-1:0]        B_data;
    logic                 busy, done, overflow;
    logic [N*N*AW-1:0]    result;
    logic                 busy2, done2, overflow2;
    logic [N*N*AW2-1:0]   result2;

    always #5 HCLK = ~HCLK;

    matrix_mult_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) dut (
        .HCLK(HCLK), .reset(reset), .start(start), .accumulate(accumulate),
        .signed_mode(signed_mode), .A_data(A_data), .B_data(B_data),
        .busy(busy), .done(done), .overflow(overflow), .result(result));

    matrix_mult_array #(.N(N), .DATA_W(DW), .ACC_W(AW2)) dut24 (
        .HCLK(HCLK), .reset(reset), .start(start), .accumulate(accumulate),
        .signed_mode(signed_mode), .A_data(A_data), .B_data(B_data),
        .busy(busy2), .done(done2), .overflow(overflow2), .result(result2));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: plain integer matrix arithmetic, clamped after every k step.
    logic [AW-1:0] m_acc [N][N];
    logic          m_ovf;

    typedef struct {
        logic          sgn;
        logic [7:0]    fa;
        logic [7:0]    fb;
        logic [15:0]   e16;
        logic          eo;
        logic [23:0]   e24;
    } vec_t;
    vec_t vt [7];

    task automatic check_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint elem(input logic [VW-1:0] m, input int r, input int c, input logic sgn);
        logic [DW-1:0] e;
        e = m[DW*(r*N+c) +: DW];
        return sgn ? longint'($signed(e)) : longint'(e);
    endfunction

    function automatic logic [VW-1:0] fill(input logic [7:0] v);
        logic [VW-1:0] m;
        for (int i = 0; i < N*N; i++) m[DW*i +: DW] = v;
        return m;
    endfunction

    function automatic logic [VW-1:0] ident();
        logic [VW-1:0] m;
        m = '0;
        for (int i = 0; i < N; i++) m[DW*(i*N+i) +: DW] = 8'd1;
        return m;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++) m_acc[i][j] = '0;
        m_ovf = 1'b0;
    endtask

    task automatic model_op(input logic acc, input logic sgn, input logic [VW-1:0] a, input logic [VW-1:0] b);
        longint lo, hi, cur, s;
        if (!acc) model_reset();
        m_ovf = 1'b0;
        lo = sgn ? -(longint'(1) << (AW-1)) : 0;
        hi = sgn ? (longint'(1) << (AW-1)) - 1 : (longint'(1) << AW) - 1;
        for (int k = 0; k < N; k++)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    cur = sgn ? longint'($signed(m_acc[i][j])) : longint'(m_acc[i][j]);
                    s = cur + elem(a, i, k, sgn) * elem(b, k, j, sgn);
                    if (s > hi) begin s = hi; m_ovf = 1'b1; end
                    else if (s < lo) begin s = lo; m_ovf = 1'b1; end
                    m_acc[i][j] = AW'(s);
                end
    endtask

    task automatic check_model(input string name);
        int bad, fi;
        logic [AW-1:0] got, want;
        bad = 0; fi = 0; got = '0; want = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                if (result[AW*(i*N+j) +: AW] !== m_acc[i][j]) begin
                    if (bad == 0) begin
                        fi = i*N+j; got = result[AW*(i*N+j) +: AW]; want = m_acc[i][j];
                    end
                    bad++;
                end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad elements, first idx %0d got %h expected %h", name, bad, fi, got, want);
        end
        check_int({name, "_ovf"}, overflow, m_ovf);
    endtask

    task automatic check_const(input string name, input logic wide, input logic [AW2-1:0] val);
        int bad;
        logic [AW2-1:0] got, first;
        bad = 0; first = '0;
        for (int i = 0; i < N*N; i++) begin
            got = wide ? result2[AW2*i +: AW2] : AW2'(result[AW*i +: AW]);
            if (got !== (wide ? val : AW2'(val[AW-1:0]))) begin
                if (bad == 0) first = got;
                bad++;
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL %s: %0d bad elements, first got %h expected %h", name, bad, first, val);
        end
    endtask

    task automatic run_op(input logic acc, input logic sgn, input logic [VW-1:0] a, input logic [VW-1:0] b,
                          input bit immediate, output int lat, output int bcnt);
        if (!immediate) @(negedge HCLK);
        A_data = a; B_data = b; accumulate = acc; signed_mode = sgn; start = 1'b1;
        @(posedge HCLK);
        model_op(acc, sgn, a, b);
        @(negedge HCLK);
        start = 1'b0; A_data = ~a; B_data = ~b; accumulate = ~acc; signed_mode = ~sgn;
        lat = -1; bcnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (c > 0) @(negedge HCLK);
            if (busy) bcnt++;
            if (done) begin lat = c; break; end
        end
    endtask

    initial begin
        int lat, bcnt, ndone;
        logic [VW-1:0] bm, ra, rb;
        logic [7:0] mask;
        logic ra_acc, ra_sgn;

        vt[0] = '{1'b0, 8'hFF, 8'hFF, 16'hFFFF, 1'b1, 24'd520200};
        vt[1] = '{1'b1, 8'hFF, 8'h02, 16'hFFF0, 1'b0, 24'hFFFFF0};
        vt[2] = '{1'b1, 8'h80, 8'h80, 16'h7FFF, 1'b1, 24'h020000};
        vt[3] = '{1'b0, 8'h01, 8'h01, 16'h0008, 1'b0, 24'h000008};
        vt[4] = '{1'b1, 8'h7F, 8'h7F, 16'h7FFF, 1'b1, 24'h01F808};
        vt[5] = '{1'b1, 8'h80, 8'h7F, 16'h8000, 1'b1, 24'hFE0400};
        vt[6] = '{1'b0, 8'h02, 8'h03, 16'h0030, 1'b0, 24'h000030};

        reset = 1'b1; start = 1'b0; accumulate = 1'b0; signed_mode = 1'b0;
        A_data = '0; B_data = '0;
        model_reset();
        repeat (3) @(negedge HCLK);
        check_int("reset_busy", busy, 0);
        check_int("reset_done", done, 0);
        check_int("reset_ovf", overflow, 0);
        check_int("reset_result_zero", (result == '0), 1);
        reset = 1'b0;

        // Identity times B gives B, with exact done/busy timing.
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) bm[DW*(r*N+c) +: DW] = 8'(r*8+c);
        run_op(1'b0, 1'b0, ident(), bm, 1'b0, lat, bcnt);
        check_int("ident_latency", lat, N+2);
        check_int("ident_busy_cycles", bcnt, N+2);
        check_model("ident_result");
        check_int("ident_elem_63", result[AW*63 +: AW], 63);
        @(negedge HCLK);
        check_int("done_one_cycle", done, 0);

        // Constant-matrix vectors, both accumulator widths.
        for (int v = 0; v < 7; v++) begin
            run_op(1'b0, vt[v].sgn, fill(vt[v].fa), fill(vt[v].fb), 1'b0, lat, bcnt);
            check_int($sformatf("vec%0d_latency", v), lat, N+2);
            check_const($sformatf("vec%0d_acc16", v), 1'b0, AW2'(vt[v].e16));
            check_int($sformatf("vec%0d_ovf16", v), overflow, vt[v].eo);
            check_const($sformatf("vec%0d_acc24", v), 1'b1, vt[v].e24);
            check_int($sformatf("vec%0d_ovf24", v), overflow2, 0);
            check_int($sformatf("vec%0d_done24", v), done2, 1);
        end

        // Accumulate sequence: 1, 2, then cleared back to 1.
        run_op(1'b0, 1'b0, ident(), fill(8'd1), 1'b0, lat, bcnt);
        check_const("accum_first", 1'b0, 24'd1);
        run_op(1'b1, 1'b0, ident(), fill(8'd1), 1'b0, lat, bcnt);
        check_const("accum_second", 1'b0, 24'd2);
        run_op(1'b0, 1'b0, ident(), fill(8'd1), 1'b0, lat, bcnt);
        check_const("accum_cleared", 1'b0, 24'd1);

        // Start while busy is ignored.
        ra = fill(8'd3);
        @(negedge HCLK);
        A_data = ra; B_data = ident(); accumulate = 1'b0; signed_mode = 1'b0; start = 1'b1;
        @(posedge HCLK);
        model_op(1'b0, 1'b0, ra, ident());
        @(negedge HCLK);
        start = 1'b0;
        ndone = 0;
        for (int c = 1; c <= 3*N; c++) begin
            @(negedge HCLK);
            start = (c >= 2 && c <= 5) ? 1'b1 : 1'b0;
            A_data = fill(8'd9);
            if (done) ndone++;
        end
        start = 1'b0;
        check_int("busy_start_done_count", ndone, 1);
        check_model("busy_start_result");

        // Back-to-back: start in the done cycle.
        ra = fill(8'd2); rb = fill(8'd5);
        run_op(1'b0, 1'b0, ra, rb, 1'b0, lat, bcnt);
        check_model("b2b_first");
        run_op(1'b0, 1'b1, ident(), fill(8'hFE), 1'b1, lat, bcnt);
        check_int("b2b_latency", lat, N+2);
        check_model("b2b_second");

        // Reset during MAC at k=3.
        @(negedge HCLK);
        A_data = fill(8'hFF); B_data = fill(8'hFF); accumulate = 1'b0; signed_mode = 1'b0; start = 1'b1;
        @(posedge HCLK);
        @(negedge HCLK);
        start = 1'b0;
        repeat (3) @(negedge HCLK);
        check_int("pre_reset_ovf", overflow, 1);
        reset = 1'b1;
        @(negedge HCLK);
        check_int("midreset_busy", busy, 0);
        check_int("midreset_done", done, 0);
        check_int("midreset_ovf", overflow, 0);
        check_int("midreset_result_zero", (result == '0), 1);
        reset = 1'b0;
        model_reset();
        ndone = 0;
        for (int c = 0; c < 2*N; c++) begin
            @(negedge HCLK);
            if (done) ndone++;
        end
        check_int("midreset_no_done", ndone, 0);
        run_op(1'b1, 1'b0, ident(), fill(8'd1), 1'b0, lat, bcnt);
        check_const("post_reset_accum", 1'b0, 24'd1);

        // Randomised operations against the model.
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 2))
                0: mask = 8'hFF;
                1: mask = 8'h0F;
                default: mask = 8'h03;
            endcase
            for (int i = 0; i < N*N; i++) begin
                ra[DW*i +: DW] = 8'($urandom) & mask;
                rb[DW*i +: DW] = 8'($urandom) & mask;
            end
            ra_acc = 1'($urandom);
            ra_sgn = 1'($urandom);
            run_op(ra_acc, ra_sgn, ra, rb, 1'b0, lat, bcnt);
            check_int($sformatf("rand%0d_latency", t), lat, N+2);
            check_model($sformatf("rand%0d", t));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
